// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified SRAM port arbiter.
// State and grant encodings plus wait counter width.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_t;

    localparam int WAIT_CNT_LEN = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and SRAM signal bundle for mem_port_arbiter.
// master: pipeline/SRAM side, slave: arbiter side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              freeze;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_we;
    logic [DATA_W-1:0] sram_rdata;

    modport master (
        output if_req, if_addr, mem_r_en, mem_w_en,
        output mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
        input  freeze, sram_addr, sram_wdata, sram_we
    );

    modport slave (
        input  if_req, if_addr, mem_r_en, mem_w_en,
        input  mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready,
        output freeze, sram_addr, sram_wdata, sram_we
    );
endinterface

// File: rtl/mem_port_arbiter_if_fetch_buffer.sv
// One-entry fetch buffer (valid, tag, data); built only with IF_BUF_EN.
// Refilled by SRAM fetches, invalidated by a store to the tagged word.
`ifdef IF_BUF_EN
module if_fetch_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inval_en,
    input  logic [ADDR_W-1:0] inval_addr
);
    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
            tag_q   <= fill_addr;
            data_q  <= fill_data;
        end else if (inval_en && inval_addr == tag_q) begin
            valid_q <= 1'b0;
        end
    end

    assign hit      = valid_q && (tag_q == lookup_addr);
    assign hit_data = data_q;
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one SRAM port, MEM first.
// Optional one-entry fetch buffer under IF_BUF_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [WAIT_CNT_LEN-1:0] CNT_INIT =
        WAIT_CNT_LEN'(WAIT_CYCLES - 1);

    arb_state_t              state_q, state_d;
    gnt_t                    gnt_q;
    logic [WAIT_CNT_LEN-1:0] cnt_q;
    logic                    we_q;
    logic                    mem_done_q, if_done_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       if_rdata_q, mem_rdata_q;

    logic mem_any, mem_req, if_req_e;
    logic grant_mem, grant_if, buf_resp, last;
    logic if_ready, mem_ready, freeze;
    logic              buf_hit;
    logic [DATA_W-1:0] buf_data;

    always_comb begin
        mem_any   = bus.mem_r_en | bus.mem_w_en;
        mem_req   = mem_any & ~mem_done_q;
        if_req_e  = bus.if_req & ~if_done_q;
        state_d   = state_q;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        buf_resp  = 1'b0;
        last      = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (mem_req) begin
                    grant_mem = 1'b1;
                    state_d   = ARB_BUSY;
                end else if (if_req_e && buf_hit) begin
                    buf_resp = 1'b1;
                    state_d  = ARB_RESP;
                end else if (if_req_e) begin
                    grant_if = 1'b1;
                    state_d  = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (cnt_q == '0) begin
                    last    = 1'b1;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    assign if_ready  = (state_q == ARB_RESP) && (gnt_q == GNT_IF);
    assign mem_ready = (state_q == ARB_RESP) && (gnt_q == GNT_MEM);
    // Hold the pipeline until every active requester got its one service.
    assign freeze = (mem_any & ~(mem_done_q | mem_ready))
                  | (bus.if_req & ~(if_done_q | if_ready));

    assign bus.if_ready   = if_ready;
    assign bus.mem_ready  = mem_ready;
    assign bus.freeze     = freeze;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.sram_we    = (state_q == ARB_BUSY) && we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= GNT_IF;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            mem_done_q  <= 1'b0;
            if_done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_BUSY)
                cnt_q <= cnt_q - 1'b1;
            if (grant_mem || grant_if)
                cnt_q <= CNT_INIT;
            if (grant_mem) begin
                gnt_q   <= GNT_MEM;
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
                we_q    <= bus.mem_w_en;
            end
            if (grant_if) begin
                gnt_q  <= GNT_IF;
                addr_q <= bus.if_addr;
                we_q   <= 1'b0;
            end
            if (buf_resp) begin
                gnt_q      <= GNT_IF;
                if_rdata_q <= buf_data;
            end
            if (last && !we_q) begin
                if (gnt_q == GNT_MEM)
                    mem_rdata_q <= bus.sram_rdata;
                else
                    if_rdata_q <= bus.sram_rdata;
            end
            mem_done_q <= freeze & (mem_done_q | mem_ready);
            if_done_q  <= freeze & (if_done_q | if_ready);
        end
    end

`ifdef IF_BUF_EN
    if_fetch_buffer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fbuf (
        .clk        (clk),
        .rst        (rst),
        .lookup_addr(bus.if_addr),
        .hit        (buf_hit),
        .hit_data   (buf_data),
        .fill_en    (last && gnt_q == GNT_IF),
        .fill_addr  (addr_q),
        .fill_data  (bus.sram_rdata),
        .inval_en   (grant_mem && bus.mem_w_en),
        .inval_addr (bus.mem_addr)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand sequences for WAIT_CYCLES=1 and fetch-buffer behaviour.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        logic        rst, ifr;
        logic [31:0] ia;
        logic        mr, mw;
        logic [31:0] ma, wd, sr;
        logic        irdy, mrdy, frz, we;
        logic [31:0] sa, swd, ifrd, memrd;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    function automatic void add(
        logic r, logic ifr, logic [31:0] ia,
        logic mr, logic mw, logic [31:0] ma,
        logic [31:0] wd, logic [31:0] sr,
        logic irdy, logic mrdy, logic frz, logic we,
        logic [31:0] sa, logic [31:0] swd,
        logic [31:0] ifrd, logic [31:0] memrd);
        vec_t v;
        v.rst = r; v.ifr = ifr; v.ia = ia;
        v.mr = mr; v.mw = mw; v.ma = ma;
        v.wd = wd; v.sr = sr;
        v.irdy = irdy; v.mrdy = mrdy; v.frz = frz; v.we = we;
        v.sa = sa; v.swd = swd; v.ifrd = ifrd; v.memrd = memrd;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fetch(logic [31:0] a, logic [31:0] d,
                         int exp_lat, logic [31:0] exp_d, string nm);
        int lat;
        logic [31:0] got;
        lat = -1;
        got = '0;
        bus.if_req = 1'b1;
        bus.if_addr = a;
        bus.sram_rdata = d;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.if_ready) begin
                lat = c;
                got = bus.if_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        chk({nm, "_lat"}, 160'(lat), 160'(exp_lat));
        chk({nm, "_data"}, 160'(got), 160'(exp_d));
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic store(logic [31:0] a, logic [31:0] d, string nm);
        int lat;
        lat = -1;
        bus.mem_w_en = 1'b1;
        bus.mem_addr = a;
        bus.mem_wdata = d;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.mem_ready) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk({nm, "_lat"}, 160'(lat), 160'(3));
        @(posedge clk); #1;
        bus.mem_w_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] D;
        logic [31:0] B;
        D = 32'hDEADBEEF;
        B = 32'h00000BAD;
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0;
        bus.mem_r_en = 0; bus.mem_w_en = 0;
        bus.mem_addr = 0; bus.mem_wdata = 0;
        bus.sram_rdata = 0;
        bus1.if_req = 0; bus1.if_addr = 0;
        bus1.mem_r_en = 0; bus1.mem_w_en = 0;
        bus1.mem_addr = 0; bus1.mem_wdata = 0;
        bus1.sram_rdata = 0;

        // reset / idle
        add(1,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0);
        add(0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0);
        // IF only
        add(0,1,'h10, 0,0,0,0,D, 0,0,1,0, 0,0,0,0);
        add(0,1,'h10, 0,0,0,0,D, 0,0,1,0, 'h10,0,0,0);
        add(0,1,'h10, 0,0,0,0,D, 0,0,1,0, 'h10,0,0,0);
        add(0,1,'h10, 0,0,0,0,D, 1,0,0,0, 'h10,0,D,0);
        add(0,0,0, 0,0,0,0,0, 0,0,0,0, 'h10,0,D,0);
        // load + fetch together
        add(0,1,'h08, 1,0,'h40,0,'h11, 0,0,1,0, 'h10,0,D,0);
        add(0,1,'h08, 1,0,'h40,0,'h11, 0,0,1,0, 'h40,0,D,0);
        add(0,1,'h08, 1,0,'h40,0,'h11, 0,0,1,0, 'h40,0,D,0);
        add(0,1,'h08, 1,0,'h40,0,'h22, 0,1,1,0, 'h40,0,D,'h11);
        add(0,1,'h08, 1,0,'h40,0,'h22, 0,0,1,0, 'h40,0,D,'h11);
        add(0,1,'h08, 1,0,'h40,0,'h22, 0,0,1,0, 'h08,0,D,'h11);
        add(0,1,'h08, 1,0,'h40,0,'h22, 0,0,1,0, 'h08,0,D,'h11);
        add(0,1,'h08, 1,0,'h40,0,'h22, 1,0,0,0, 'h08,0,'h22,'h11);
        add(0,0,0, 0,0,0,0,0, 0,0,0,0, 'h08,0,'h22,'h11);
        // store
        add(0,0,0, 0,1,'h20,'h55,B, 0,0,1,0, 'h08,0,'h22,'h11);
        add(0,0,0, 0,1,'h20,'h55,B, 0,0,1,1, 'h20,'h55,'h22,'h11);
        add(0,0,0, 0,1,'h20,'h55,B, 0,0,1,1, 'h20,'h55,'h22,'h11);
        add(0,0,0, 0,1,'h20,'h55,B, 0,1,0,0, 'h20,'h55,'h22,'h11);
        add(0,0,0, 0,0,0,0,0, 0,0,0,0, 'h20,'h55,'h22,'h11);
        // read+write together acts as a write
        add(0,0,0, 1,1,'h30,'h77,B, 0,0,1,0, 'h20,'h55,'h22,'h11);
        add(0,0,0, 1,1,'h30,'h77,B, 0,0,1,1, 'h30,'h77,'h22,'h11);
        add(0,0,0, 1,1,'h30,'h77,B, 0,0,1,1, 'h30,'h77,'h22,'h11);
        add(0,0,0, 1,1,'h30,'h77,B, 0,1,0,0, 'h30,'h77,'h22,'h11);
        add(0,0,0, 0,0,0,0,0, 0,0,0,0, 'h30,'h77,'h22,'h11);
        // reset in the middle of a write
        add(0,0,0, 0,1,'h44,'h99,B, 0,0,1,0, 'h30,'h77,'h22,'h11);
        add(0,0,0, 0,1,'h44,'h99,B, 0,0,1,1, 'h44,'h99,'h22,'h11);
        add(1,0,0, 0,1,'h44,'h99,B, 0,0,1,1, 'h44,'h99,'h22,'h11);
        add(1,0,0, 0,1,'h44,'h99,B, 0,0,1,0, 0,0,0,0);
        add(0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            bus.if_req = tbl[i].ifr;
            bus.if_addr = tbl[i].ia;
            bus.mem_r_en = tbl[i].mr;
            bus.mem_w_en = tbl[i].mw;
            bus.mem_addr = tbl[i].ma;
            bus.mem_wdata = tbl[i].wd;
            bus.sram_rdata = tbl[i].sr;
            @(negedge clk);
            chk($sformatf("row%0d", i),
                160'({bus.if_ready, bus.mem_ready, bus.freeze,
                      bus.sram_we, bus.sram_addr, bus.sram_wdata,
                      bus.if_rdata, bus.mem_rdata}),
                160'({tbl[i].irdy, tbl[i].mrdy, tbl[i].frz,
                      tbl[i].we, tbl[i].sa, tbl[i].swd,
                      tbl[i].ifrd, tbl[i].memrd}));
            @(posedge clk); #1;
        end

        // WAIT_CYCLES=1 fetch: ready two cycles after request
        bus1.if_req = 1'b1;
        bus1.if_addr = 32'h14;
        bus1.sram_rdata = 32'hCAFE0001;
        @(negedge clk);
        chk("w1_c0", 160'({bus1.if_ready, bus1.freeze}), 160'(2'b01));
        @(posedge clk); #1;
        @(negedge clk);
        chk("w1_c1", 160'({bus1.if_ready, bus1.freeze}), 160'(2'b01));
        @(posedge clk); #1;
        @(negedge clk);
        chk("w1_c2", 160'({bus1.if_ready, bus1.freeze}), 160'(2'b10));
        chk("w1_data", 160'(bus1.if_rdata), 160'(32'hCAFE0001));
        @(posedge clk); #1;
        bus1.if_req = 1'b0;
        @(posedge clk); #1;

        // repeated fetch, store invalidation, refetch
        fetch(32'h10, 32'hA1, 3, 32'hA1, "f1");
`ifdef IF_BUF_EN
        fetch(32'h10, 32'hB2, 1, 32'hA1, "f2");
`else
        fetch(32'h10, 32'hB2, 3, 32'hB2, "f2");
`endif
        store(32'h10, 32'h66, "st");
        fetch(32'h10, 32'hC3, 3, 32'hC3, "f3");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified SRAM between the IF stage (instruction fetch) and the MEM stage (LD/ST from the decode controls MEM_R_EN/MEM_W_EN).
- Multi-cycle FSM with a fixed wait-state counter.
- MEM has priority over IF.
- Drives a global freeze that holds the pipeline until every requester active this cycle has been served once.

Parameters:
ADDR_W, 32, address width (word address)
DATA_W, 32, data word width
WAIT_CYCLES, 2, SRAM access time in cycles; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  IF stage requests a fetch
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, registered and held until next IF capture
if_ready  out  1  one-cycle pulse: IF request served
mem_r_en  in  1  MEM stage load request
mem_w_en  in  1  MEM stage store request
mem_addr  in  ADDR_W  load/store address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, registered and held until next load capture
mem_ready  out  1  one-cycle pulse: MEM request served
freeze  out  1  holds PC and all pipeline registers
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_we  out  1  SRAM write enable
sram_rdata  in  DATA_W  SRAM read data, valid at end of last wait cycle

Behaviour:
- Reset: state=IDLE; if_ready, mem_ready, sram_we=0; sram_addr, sram_wdata, if_rdata, mem_rdata=0; done flags cleared. Reset mid-access aborts it; sram_we is low from the first cycle after the reset edge.
- Effective requests:
  - mem_req = (mem_r_en|mem_w_en) & ~mem_done.
  - if_req_e = if_req & ~if_done.
  - mem_r_en & mem_w_en together is treated as a write.
- State IDLE:
  - If mem_req: grant MEM, latch addr, wdata and we=mem_w_en.
  - Else if if_req_e: grant IF, we=0.
  - On a grant: cnt<=WAIT_CYCLES-1, go to BUSY.
  - Otherwise stay in IDLE.
- State BUSY:
  - sram_* driven from latched registers; sram_we=latched we for every BUSY cycle.
  - cnt decrements each cycle.
  - At cnt==0: capture sram_rdata into the granted requester's rdata register (not for writes), go to RESP.
- State RESP:
  - Pulse the granted requester's ready for exactly one cycle; sram_we=0; go to IDLE.
- Latency: request seen in IDLE at cycle 0 gives ready at cycle WAIT_CYCLES+1.
  - Back-to-back accesses need one IDLE cycle between grants.
- Done flags:
  - mem_done is set when mem_ready pulses while freeze stays high the same cycle; if_done likewise.
  - Both clear on any cycle with freeze=0.
  - This prevents re-serving a requester that is being held by freeze.
- freeze (combinational) = ((mem_r_en|mem_w_en) & ~(mem_done|mem_ready)) | (if_req & ~(if_done|if_ready)).
- Simultaneous IF+MEM: MEM served first, then IF; freeze deasserts only in the IF RESP cycle.
- Outside BUSY: sram_addr/sram_wdata hold their last value.
- Requester inputs are sampled only at grant; changes during BUSY are ignored.

Optional Feature:
IF_BUF_EN
- Defined: one-entry fetch buffer (valid, tag, data).
  - In IDLE with no mem_req, if_req_e and valid and tag==if_addr: go straight to RESP without SRAM access; if_rdata<=buffered data; latency 1.
  - Every SRAM IF read refills the buffer.
  - A MEM write with addr==tag clears valid at grant.
  - rst clears valid.
- Undefined: no buffer; every fetch costs WAIT_CYCLES+1.

Decomposition:
- defines.v gains:
  - state encodings ARB_IDLE/ARB_BUSY/ARB_RESP (2 bits)
  - grant encoding GNT_IF/GNT_MEM
  - WAIT_CNT_LEN=4
- One natural sub-module: if_fetch_buffer (tag compare, refill, invalidate), instantiated only under IF_BUF_EN.

Test Plan:
- Reset: rst=1 during a BUSY write -> next cycle state IDLE, sram_we=0, freeze follows inputs, rdata registers=0.
- IF only, WAIT_CYCLES=2: if_req=1, if_addr=0x10, SRAM returns 0xDEADBEEF -> sram_addr=0x10 cycles 1-2, if_ready pulse cycle 3, if_rdata=0xDEADBEEF, freeze high cycles 0-2, low cycle 3.
- Load+fetch together: mem_r_en=1 addr=0x40 (data 0x11), if_req=1 addr=0x08 (data 0x22) -> mem_ready cycle 3 with mem_rdata=0x11, freeze stays high, IF granted cycle 4, if_ready cycle 7 with 0x22, freeze low cycle 7; MEM not re-served.
- Store: mem_w_en=1 addr=0x20 wdata=0x55 -> sram_we=1 exactly cycles 1-2 with sram_wdata=0x55; mem_rdata unchanged.
- WAIT_CYCLES=1: IF fetch -> if_ready cycle 2.
- IF_BUF_EN: fetch 0x10 twice -> second if_ready one cycle after request, no BUSY. Store to 0x10, then fetch 0x10 -> full SRAM latency.
